ram_initiator: RTL and testbench
================================

# ram_initiator

Single-port request/response initiator that drives one port of the team's byte-masked, 1-cycle-read-latency RAM (en / wen / addr / wdata / rdata). It accepts read and write requests on a valid/ready front end and issues each one to the RAM port in the cycle it is accepted. It captures the RAM read data one cycle later and returns exactly one in-order response per request through a 3-entry response buffer. Fetch and load/store units sit upstream of it; the RAM port sits downstream.

## Interface
- NDATA, 64, number of RAM words
- NDATABYTE, 4, bytes per word; data width is NDATABYTE*8
- NADDRBIT, $clog2(NDATA), local, word address width
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- i_req_valid  input  1  request present
- o_req_ready  output  1  request can be accepted this cycle
- i_req_wen  input  NDATABYTE  byte write mask; all-zero means read
- i_req_addr  input  NADDRBIT  word address
- i_req_wdata  input  NDATABYTE*8  write data
- o_rsp_valid  output  1  response present
- i_rsp_ready  input  1  consumer takes response
- o_rsp_write  output  1  response belongs to a write
- o_rsp_rdata  output  NDATABYTE*8  read data; zero for writes
- o_ram_en  output  1  RAM port enable
- o_ram_wen  output  NDATABYTE  RAM byte write enables
- o_ram_addr  output  NADDRBIT  RAM address
- o_ram_wdata  output  NDATABYTE*8  RAM write data
- i_ram_rdata  input  NDATABYTE*8  RAM read data, valid the cycle after en
- o_idle  output  1  nothing in flight and response buffer empty

## Operation
- Accept: a request is accepted when i_req_valid & o_req_ready.
- RAM drive is combinational in the accept cycle:
  - o_ram_en = accept.
  - o_ram_wen = i_req_wen when accepted, else 0.
  - o_ram_addr and o_ram_wdata pass straight through from the request.
- In-flight register:
  - inflight is set to accept every cycle.
  - inflight_write is set to (accept & |i_req_wen).
- Capture: when inflight=1, push one entry {write = inflight_write, data = inflight_write ? 0 : i_ram_rdata} into the response FIFO.
- Response FIFO:
  - 3 entries, head/tail pointers wrap modulo 3, count ranges 0..3.
  - o_rsp_valid = (count != 0).
  - o_rsp_write and o_rsp_rdata show the head entry, and are 0 when empty.
  - Pop on o_rsp_valid & i_rsp_ready.
  - Push and pop in the same cycle leave count unchanged.
- Credit rule: o_req_ready = (count + inflight) < 3, computed from registers only. There is no combinational path from i_rsp_ready or i_req_valid to o_req_ready.
- The credit rule guarantees a push never finds the FIFO full; overflow is unreachable. Verification asserts it.
- Ordering: responses come out in acceptance order. Each accepted request yields exactly one response.
- Write data: a write never returns RAM data (o_rsp_rdata = 0), regardless of the RAM's read-during-write value.
- o_idle = (inflight == 0) & (count == 0).
- Reset (asynchronous, active-low):
  - inflight=0, inflight_write=0, count=0, pointers=0, FIFO data=0.
  - Outputs: o_rsp_valid=0, o_rsp_write=0, o_rsp_rdata=0, o_idle=1.
  - o_req_ready=0 and o_ram_en=0 / o_ram_wen=0 while reset is low. o_req_ready=1 from the first cycle after release.
  - Reset mid-operation discards in-flight and buffered responses. A write already issued to the RAM before reset is not undone.

## Timing
- Request accepted in cycle t:
  - RAM enabled in t.
  - i_ram_rdata sampled at the end of t+1.
  - o_rsp_valid high in t+2 at the earliest.
- Latency: 2 cycles from accept to response.
- Throughput: 1 request per cycle sustained while i_rsp_ready=1.
- Stall: with i_rsp_ready=0, at most 3 requests are outstanding. o_req_ready falls in the cycle after the 3rd accept.
- Release: after a pop, o_req_ready rises in the next cycle.
- Idle: with i_req_valid=0, o_ram_en=0 and the RAM port outputs carry no write (wen=0).

## Test plan
- Single read: RAM preloaded with word[5]=0xDEADBEEF; request read addr 5 at t -> o_ram_en=1, addr=5 at t; o_rsp_valid=1, o_rsp_write=0, rdata=0xDEADBEEF at t+2; o_idle=1 at t+3.
- Masked write then read: write addr 3, wen=4'b0101, wdata=0x11223344 over old 0xAABBCCDD -> write response with rdata=0; following read of addr 3 returns 0xAA22CC44.
- Streaming: 8 back-to-back reads of addr 0..7 with i_rsp_ready=1 -> o_req_ready stays 1; 8 responses on consecutive cycles starting 2 cycles after the first accept, in address order.
- Backpressure: i_rsp_ready=0 with i_req_valid=1 continuously -> exactly 3 accepts, then o_req_ready=0 and count=3. Raise i_rsp_ready for 1 cycle -> one pop; o_req_ready=1 the next cycle; order preserved.
- Reset mid-operation: assert reset asynchronously with 2 responses buffered and 1 in flight -> o_rsp_valid=0 and o_ram_en=0 immediately; after release, o_idle=1 and o_req_ready=1, and no stale response appears.
- Mixed sequence: read, write, read to the same address in consecutive cycles -> responses in order (old data, write/0, new data); the FIFO overflow assertion never fires.

Source files
------------

// File: rtl/ram_initiator.sv
// ram_initiator: valid/ready front end driving one port of a byte-masked,
// 1-cycle-read-latency RAM. Each accepted request is issued to the RAM in
// its accept cycle, its result is captured one cycle later into a 3-entry
// response FIFO, and responses leave in acceptance order.
module ram_initiator #(
    parameter  int NDATA     = 64,
    parameter  int NDATABYTE = 4,
    localparam int NADDRBIT  = $clog2(NDATA),
    localparam int DW        = NDATABYTE * 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [NDATABYTE-1:0] i_req_wen,
    input  logic [NADDRBIT-1:0]  i_req_addr,
    input  logic [DW-1:0]        i_req_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_write,
    output logic [DW-1:0]        o_rsp_rdata,
    output logic                 o_ram_en,
    output logic [NDATABYTE-1:0] o_ram_wen,
    output logic [NADDRBIT-1:0]  o_ram_addr,
    output logic [DW-1:0]        o_ram_wdata,
    input  logic [DW-1:0]        i_ram_rdata,
    output logic                 o_idle
);

    logic          inflight;
    logic          inflight_write;
    logic [1:0]    count;
    logic [1:0]    head;
    logic [1:0]    tail;
    logic [DW-1:0] fifo_data [3];
    logic [2:0]    fifo_write;

    logic accept;
    logic push;
    logic pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit: an issued request always has a FIFO slot reserved for it, so
    // the capture never sees a full buffer. Gated by reset so nothing is
    // accepted while reset is held low.
    assign o_req_ready = reset && (({1'b0, count} + {2'b00, inflight}) < 3'd3);
    assign accept      = i_req_valid & o_req_ready;

    assign o_ram_en    = accept;
    assign o_ram_wen   = accept ? i_req_wen : '0;
    assign o_ram_addr  = i_req_addr;
    assign o_ram_wdata = i_req_wdata;

    assign push        = inflight;
    assign o_rsp_valid = (count != 2'd0);
    assign pop         = o_rsp_valid & i_rsp_ready;
    assign o_rsp_write = o_rsp_valid ? fifo_write[head] : 1'b0;
    assign o_rsp_rdata = o_rsp_valid ? fifo_data[head] : '0;
    assign o_idle      = !inflight && (count == 2'd0);

    // Track the single request whose RAM read data arrives next cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight       <= 1'b0;
            inflight_write <= 1'b0;
        end else begin
            inflight       <= accept;
            inflight_write <= accept & (|i_req_wen);
        end
    end

    // Response FIFO: capture on the cycle after issue, pop on handshake.
    // Writes store zero so RAM read-during-write data never leaks out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count      <= 2'd0;
            head       <= 2'd0;
            tail       <= 2'd0;
            fifo_write <= '0;
            for (int i = 0; i < 3; i++) fifo_data[i] <= '0;
        end else begin
            if (push) begin
                fifo_data[tail]  <= inflight_write ? '0 : i_ram_rdata;
                fifo_write[tail] <= inflight_write;
                tail             <= ptr_next(tail);
            end
            if (pop) head <= ptr_next(head);
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The credit rule makes a push into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !(push && count == 2'd3));

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator with a behavioral byte-masked RAM that
// has one cycle of read latency and returns old data on read-during-write.
module tb_ram_initiator;
    localparam int NDATA = 64;
    localparam int NB    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [NB-1:0] i_req_wen = '0;
    logic [5:0]    i_req_addr = '0;
    logic [31:0]   i_req_wdata = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic          o_rsp_write;
    logic [31:0]   o_rsp_rdata;
    logic          o_ram_en;
    logic [NB-1:0] o_ram_wen;
    logic [5:0]    o_ram_addr;
    logic [31:0]   o_ram_wdata;
    logic [31:0]   ram_rdata = '0;
    logic          o_idle;

    logic          pl_en = 1'b0;
    logic [5:0]    pl_addr = '0;
    logic [31:0]   pl_data = '0;
    logic [31:0]   mem [NDATA];

    int total = 0;
    int bad   = 0;

    ram_initiator #(.NDATA(NDATA), .NDATABYTE(NB)) dut (
        .clock(clock), .reset(reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_wen(i_req_wen), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_write(o_rsp_write), .o_rsp_rdata(o_rsp_rdata),
        .o_ram_en(o_ram_en), .o_ram_wen(o_ram_wen), .o_ram_addr(o_ram_addr),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata), .o_idle(o_idle)
    );

    always #5 clock = ~clock;

    // RAM model with a bench-side preload port.
    always @(posedge clock) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (o_ram_en) begin
            for (int b = 0; b < NB; b++)
                if (o_ram_wen[b]) mem[o_ram_addr][b*8 +: 8] <= o_ram_wdata[b*8 +: 8];
            ram_rdata <= mem[o_ram_addr];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        i_req_valid = 1'b1; i_req_wen = 4'hF; i_req_addr = 6'd1;
        #1;
        total++; if (o_ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en got=%0b want=0", o_ram_en); end
        total++; if (o_ram_wen !== 4'h0) begin bad++; $display("FAIL rst_ram_wen got=%h want=0", o_ram_wen); end
        total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%0b want=0", o_req_ready); end
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0b want=0", o_rsp_valid); end
        total++; if (o_rsp_write !== 1'b0 || o_rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_data got=%0b/%h want=0/0", o_rsp_write, o_rsp_rdata); end
        total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%0b want=1", o_idle); end
        i_req_valid = 1'b0; i_req_wen = '0;
        reset = 1'b1;
        #1;
        total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL rel_req_ready got=%0b want=1", o_req_ready); end
        tick();
    endtask

    task automatic test_single_read();
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b1; i_req_wen = '0; i_req_addr = 6'd5;
        #1;
        total++; if (o_ram_en !== 1'b1 || o_ram_addr !== 6'd5 || o_ram_wen !== 4'h0) begin bad++; $display("FAIL rd_issue got en=%0b addr=%0d wen=%h want 1/5/0", o_ram_en, o_ram_addr, o_ram_wen); end
        tick();
        i_req_valid = 1'b0;
        #1;
        total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_t1_valid got=%0b want=0", o_rsp_valid); end
        tick();
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b0 || o_rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rsp got v=%0b w=%0b d=%h want 1/0/deadbeef", o_rsp_valid, o_rsp_write, o_rsp_rdata); end
        tick();
        total++; if (o_idle !== 1'b1 || o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_idle got idle=%0b v=%0b want 1/0", o_idle, o_rsp_valid); end
    endtask

    task automatic test_masked_write();
        i_req_valid = 1'b1; i_req_wen = 4'b0101; i_req_addr = 6'd3; i_req_wdata = 32'h11223344;
        #1;
        total++; if (o_ram_wen !== 4'b0101 || o_ram_wdata !== 32'h11223344) begin bad++; $display("FAIL wr_issue got wen=%h d=%h want 5/11223344", o_ram_wen, o_ram_wdata); end
        tick();
        i_req_wen = '0; i_req_wdata = '0;
        tick();
        i_req_valid = 1'b0;
        #1;
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b1 || o_rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rsp got v=%0b w=%0b d=%h want 1/1/0", o_rsp_valid, o_rsp_write, o_rsp_rdata); end
        tick();
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b0 || o_rsp_rdata !== 32'hAA22CC44) begin bad++; $display("FAIL wr_readback got v=%0b w=%0b d=%h want 1/0/aa22cc44", o_rsp_valid, o_rsp_write, o_rsp_rdata); end
        tick();
    endtask

    task automatic test_streaming();
        logic [31:0] exp [8];
        for (int i = 0; i < 8; i++) exp[i] = 32'hA0 + i;
        exp[3] = 32'hAA22CC44;
        exp[5] = 32'hDEADBEEF;
        i_rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            i_req_valid = (c < 8); i_req_wen = '0; i_req_addr = 6'(c % 8);
            #1;
            if (c < 8) begin
                total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL st_ready c=%0d got=%0b want=1", c, o_req_ready); end
            end
            if (c >= 2) begin
                total++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== exp[c-2]) begin bad++; $display("FAIL st_rsp c=%0d got v=%0b d=%h want 1/%h", c, o_rsp_valid, o_rsp_rdata, exp[c-2]); end
            end
            tick();
        end
        total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL st_idle got=%0b want=1", o_idle); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        i_rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            i_req_valid = 1'b1; i_req_wen = '0; i_req_addr = 6'(10 + acc);
            #1;
            total++; if (o_req_ready !== (c < 3)) begin bad++; $display("FAIL bp_ready c=%0d got=%0b want=%0b", c, o_req_ready, (c < 3)); end
            if (o_req_ready) acc++;
            tick();
        end
        total++; if (acc != 3) begin bad++; $display("FAIL bp_accepts got=%0d want=3", acc); end
        i_rsp_ready = 1'b1; i_req_addr = 6'd13;
        #1;
        total++; if (o_rsp_rdata !== 32'hB0 || o_req_ready !== 1'b0) begin bad++; $display("FAIL bp_pop got d=%h rdy=%0b want b0/0", o_rsp_rdata, o_req_ready); end
        tick();
        i_rsp_ready = 1'b0;
        #1;
        total++; if (o_req_ready !== 1'b1 || o_rsp_rdata !== 32'hB1 || o_ram_en !== 1'b1) begin bad++; $display("FAIL bp_release got rdy=%0b d=%h en=%0b want 1/b1/1", o_req_ready, o_rsp_rdata, o_ram_en); end
        tick();
        i_req_valid = 1'b0; i_rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'hB1 + k) begin bad++; $display("FAIL bp_drain k=%0d got v=%0b d=%h want 1/%h", k, o_rsp_valid, o_rsp_rdata, 32'hB1 + k); end
            tick();
        end
        total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL bp_idle got=%0b want=1", o_idle); end
    endtask

    task automatic test_reset_mid();
        i_rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_req_valid = 1'b1; i_req_wen = '0; i_req_addr = 6'(16 + c);
            tick();
        end
        i_req_addr = 6'd19;
        #1;
        total++; if (o_rsp_valid !== 1'b1 || o_req_ready !== 1'b0) begin bad++; $display("FAIL rm_pre got v=%0b rdy=%0b want 1/0", o_rsp_valid, o_req_ready); end
        reset = 1'b0;
        #1;
        total++; if (o_rsp_valid !== 1'b0 || o_ram_en !== 1'b0 || o_req_ready !== 1'b0) begin bad++; $display("FAIL rm_async got v=%0b en=%0b rdy=%0b want 0/0/0", o_rsp_valid, o_ram_en, o_req_ready); end
        tick();
        i_req_valid = 1'b0; i_rsp_ready = 1'b1;
        reset = 1'b1;
        #1;
        total++; if (o_idle !== 1'b1 || o_req_ready !== 1'b1) begin bad++; $display("FAIL rm_release got idle=%0b rdy=%0b want 1/1", o_idle, o_req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (o_rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_stale k=%0d got=%0b want=0", k, o_rsp_valid); end
        end
    endtask

    task automatic test_mixed();
        i_rsp_ready = 1'b1;
        i_req_valid = 1'b1; i_req_wen = '0; i_req_addr = 6'd20;
        tick();
        i_req_wen = 4'hF; i_req_wdata = 32'hCAFEF00D;
        tick();
        i_req_wen = '0; i_req_wdata = '0;
        #1;
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b0 || o_rsp_rdata !== 32'h55667788) begin bad++; $display("FAIL mx_old got v=%0b w=%0b d=%h want 1/0/55667788", o_rsp_valid, o_rsp_write, o_rsp_rdata); end
        tick();
        i_req_valid = 1'b0;
        #1;
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b1 || o_rsp_rdata !== 32'h0) begin bad++; $display("FAIL mx_wr got v=%0b w=%0b d=%h want 1/1/0", o_rsp_valid, o_rsp_write, o_rsp_rdata); end
        tick();
        total++; if (o_rsp_valid !== 1'b1 || o_rsp_write !== 1'b0 || o_rsp_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mx_new got v=%0b w=%0b d=%h want 1/0/cafef00d", o_rsp_valid, o_rsp_write, o_rsp_rdata); end
        tick();
        total++; if (o_idle !== 1'b1) begin bad++; $display("FAIL mx_idle got=%0b want=1", o_idle); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) preload(6'(i), 32'hA0 + i);
        preload(6'd3, 32'hAABBCCDD);
        preload(6'd5, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) preload(6'(10 + i), 32'hB0 + i);
        for (int i = 0; i < 4; i++) preload(6'(16 + i), 32'hC0 + i);
        preload(6'd20, 32'h55667788);
        test_reset();
        test_single_read();
        test_masked_write();
        test_streaming();
        test_backpressure();
        test_reset_mid();
        test_mixed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
